// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction/data memory responders.
package imem_pkg;

  localparam logic [31:0] INST_NOP          = 32'h0000_0013;
  localparam logic [31:0] INST_EBREAK       = 32'h0010_0073;
  localparam logic [63:0] IMEM_BASE_DEFAULT = 64'h8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } imem_rsp_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake plus the loader write port.
interface imem_responder_if #(
  parameter int ADDR_W = 64
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_inst;
  logic              rsp_err;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (
    output req_valid, req_addr, rsp_ready, wen, waddr, wdata,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, wen, waddr, wdata,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );

endinterface

// File: rtl/imem_responder_sync_fifo.sv
// First-word-fall-through FIFO, any depth >= 1; head data is visible while rd_vld_o=1.
// Write is refused when full, read is a no-op when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld_i,
  output logic             wr_rdy_o,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             rd_vld_o,
  input  logic             rd_rdy_i,
  output logic [WIDTH-1:0] rd_dat_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_rdy_o = (cnt_q != CNT_W'(DEPTH));
  assign rd_vld_o = (cnt_q != '0);
  assign push     = wr_vld_i & wr_rdy_o;
  assign pop      = rd_rdy_i & rd_vld_o;
  assign rd_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction fetch responder: response valid LATENCY cycles after accept, in order.
// Requests are credited against pipeline + FIFO occupancy, so rsp_ready=0 stalls req_ready.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          ADDR_W     = 64,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE       = IMEM_BASE_DEFAULT,
  parameter int          LATENCY    = 2,
  parameter int          FIFO_DEPTH = LATENCY + 1
) (
  input  logic              clk,
  input  logic              rst,
  imem_responder_if.slave   bus
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam int                OUT_W  = $clog2(FIFO_DEPTH + 1);

  logic [31:0]       mem_q [2**DEPTH_LOG2];
  logic [ADDR_W-1:0] req_off, wr_off;
  logic              req_err, wr_ok;
  logic              req_rdy, accept, pop;
  logic [OUT_W-1:0]  out_q, out_d;
  imem_rsp_t         rsp_now, fifo_wr_dat, fifo_rd_dat;
  logic              fifo_wr_vld, fifo_wr_rdy, fifo_rd_vld;

  assign req_off = bus.req_addr - BASE_A;
  assign req_err = (bus.req_addr[1:0] != 2'b00) | (bus.req_addr < BASE_A)
                 | ((req_off >> (DEPTH_LOG2 + 2)) != '0);

  // Asynchronous read in the accept cycle: a same-edge loader write is not yet visible.
  always_comb begin
    rsp_now.err  = req_err;
    rsp_now.inst = req_err ? INST_NOP : mem_q[req_off[DEPTH_LOG2+1:2]];
  end

  assign wr_off = bus.waddr - BASE_A;
  assign wr_ok  = (bus.waddr[1:0] == 2'b00) && (bus.waddr >= BASE_A)
               && ((wr_off >> (DEPTH_LOG2 + 2)) == '0);

  always_ff @(posedge clk) begin
    if (bus.wen && wr_ok) mem_q[wr_off[DEPTH_LOG2+1:2]] <= bus.wdata;
  end

  assign req_rdy       = rst & (out_q < OUT_W'(FIFO_DEPTH));
  assign accept        = bus.req_valid & req_rdy;
  assign pop           = fifo_rd_vld & bus.rsp_ready;
  assign bus.req_ready = req_rdy;

  always_comb begin
    out_d = out_q + OUT_W'(accept) - OUT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_q <= '0;
    else      out_q <= out_d;
  end

  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign fifo_wr_vld = accept;
      assign fifo_wr_dat = rsp_now;
    end else begin : g_pipe
      logic [LATENCY-2:0] vld_q;
      imem_rsp_t          dat_q [LATENCY-1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= '0;
          for (int i = 0; i < LATENCY - 1; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= accept;
          dat_q[0] <= rsp_now;
          for (int i = 1; i < LATENCY - 1; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign fifo_wr_vld = vld_q[LATENCY-2];
      assign fifo_wr_dat = dat_q[LATENCY-2];
    end
  endgenerate

  sync_fifo #(
    .WIDTH ($bits(imem_rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_vld_i (fifo_wr_vld & fifo_wr_rdy),
    .wr_rdy_o (fifo_wr_rdy),
    .wr_dat_i (fifo_wr_dat),
    .rd_vld_o (fifo_rd_vld),
    .rd_rdy_i (bus.rsp_ready),
    .rd_dat_o (fifo_rd_dat)
  );

  // Idle outputs read as zero rather than stale FIFO contents.
  assign bus.rsp_valid = fifo_rd_vld;
  assign bus.rsp_inst  = fifo_rd_vld ? fifo_rd_dat.inst : '0;
  assign bus.rsp_err   = fifo_rd_vld & fifo_rd_dat.err;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboarded bench for imem_responder at LATENCY=2, DEPTH_LOG2=10.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int          ADDR_W     = 64;
  localparam int          DEPTH_LOG2 = 10;
  localparam int          LATENCY    = 2;
  localparam logic [63:0] BASE       = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  imem_responder #(
    .ADDR_W     (ADDR_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BASE       (BASE),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (LATENCY + 1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  imem_rsp_t   exp_q[$];
  logic [31:0] model [1024];

  function automatic bit addr_ok(input logic [63:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && ((a - BASE) < 64'd4096);
  endfunction

  function automatic imem_rsp_t expect_rsp(input logic [63:0] a);
    imem_rsp_t r;
    if (addr_ok(a)) begin
      r.inst = model[int'((a - BASE) >> 2)];
      r.err  = 1'b0;
    end else begin
      r.inst = INST_NOP;
      r.err  = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on response handshake.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_addr  = '0;
  imem_rsp_t   mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got inst=%h err=%b, required no response", bus.rsp_inst, bus.rsp_err);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.rsp_inst !== mon_exp.inst || bus.rsp_err !== mon_exp.err) begin
            errors++;
            $display("FAIL rsp_data: got inst=%h err=%b, required inst=%h err=%b",
                     bus.rsp_inst, bus.rsp_err, mon_exp.inst, mon_exp.err);
          end
        end
      end
      if (prev_stall) begin
        checks++;
        if (bus.req_valid !== 1'b1 || bus.req_addr !== prev_addr) begin
          errors++;
          $display("FAIL req_stable: got valid=%b addr=%h, required valid=1 addr=%h",
                   bus.req_valid, bus.req_addr, prev_addr);
        end
      end
      if (bus.req_valid && bus.req_ready) exp_q.push_back(expect_rsp(bus.req_addr));
      if (bus.wen && addr_ok(bus.waddr)) model[int'((bus.waddr - BASE) >> 2)] = bus.wdata;
      prev_stall = bus.req_valid && !bus.req_ready;
      prev_addr  = bus.req_addr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [63:0] a, input logic [31:0] d);
    bus.wen   = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    cyc();
    bus.wen = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b1;
    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
    #2 rst = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    checks += 4;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b, required 0", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); end
    if (bus.rsp_inst !== 32'h0) begin errors++; $display("FAIL reset_rsp_inst: got %h, required 0", bus.rsp_inst); end
    if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b, required 0", bus.rsp_err); end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b, required 1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rsp_valid: got %b, required 0", bus.rsp_valid); end
    cyc();
  endtask

  task automatic test_load();
    load_word(BASE,                32'h0010_0093);
    load_word(BASE + 64'h4,        INST_EBREAK);
    load_word(BASE + 64'h8,        32'h0020_0113);
    load_word(BASE + 64'hFFC,      32'h0030_0193);
    // Both of these would alias word 0 if not rejected.
    load_word(BASE + 64'h1,        32'hFFFF_FFFF);
    load_word(BASE + 64'h1000,     32'hFFFF_FFFF);
  endtask

  task automatic test_latency();
    bus.req_valid = 1'b1; bus.req_addr = BASE; bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL lat_req_ready: got %b, required 1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_n0: got rsp_valid=%b, required 0", bus.rsp_valid); end
    cyc();
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_n1: got rsp_valid=%b, required 0", bus.rsp_valid); end
    cyc();
    @(negedge clk);
    checks += 3;
    if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL lat_n2: got rsp_valid=%b, required 1", bus.rsp_valid); end
    if (bus.rsp_inst !== 32'h0010_0093) begin errors++; $display("FAIL lat_inst: got %h, required 00100093", bus.rsp_inst); end
    if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL lat_err: got %b, required 0", bus.rsp_err); end
    cyc();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL lat_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a [3];
    int n = 0, first = -1, last = -1;
    a = '{BASE, BASE + 64'h4, BASE};
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c < 3);
      if (c < 3) bus.req_addr = a[c];
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready[%0d]: got %b, required 1", c, bus.req_ready); end
      end
      if (bus.rsp_valid === 1'b1) begin
        n++;
        if (first < 0) first = c;
        last = c;
      end
      cyc();
    end
    checks += 3;
    if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d, required 3", n); end
    if (first != 2) begin errors++; $display("FAIL b2b_first: got cycle %0d, required 2", first); end
    if (last != 4) begin errors++; $display("FAIL b2b_last: got cycle %0d, required 4", last); end
  endtask

  task automatic test_backpressure();
    logic [63:0] a [4];
    logic [31:0] held = '0;
    bit          have = 1'b0;
    int          k = 0, acc = 0;
    a = '{BASE, BASE + 64'h4, BASE + 64'h8, BASE};
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = a[k];
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin acc++; k++; end
      if (bus.rsp_valid === 1'b1) begin
        if (!have) begin held = bus.rsp_inst; have = 1'b1; end
        else begin
          checks++;
          if (bus.rsp_inst !== held) begin errors++; $display("FAIL bp_hold: got %h, required %h", bus.rsp_inst, held); end
        end
      end
      cyc();
    end
    @(negedge clk);
    checks += 4;
    if (acc != 3) begin errors++; $display("FAIL bp_accepted: got %0d, required 3", acc); end
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b, required 0", bus.req_ready); end
    if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b, required 1", bus.rsp_valid); end
    if (bus.rsp_inst !== 32'h0010_0093) begin errors++; $display("FAIL bp_head: got %h, required 00100093", bus.rsp_inst); end
    cyc();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_release_same: got req_ready=%b, required 0", bus.req_ready); end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_next: got req_ready=%b, required 1", bus.req_ready); end
    cyc();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_errors();
    logic [63:0] a [5];
    int nerr = 0, nok = 0;
    a = '{BASE + 64'h2, 64'h7FFF_FFFC, BASE + 64'h1000, 64'h1_8000_0000, BASE + 64'hFFC};
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c < 5);
      if (c < 5) bus.req_addr = a[c];
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        if (bus.rsp_err === 1'b1 && bus.rsp_inst === INST_NOP) nerr++;
        if (bus.rsp_err === 1'b0 && bus.rsp_inst === 32'h0030_0193) nok++;
      end
      cyc();
    end
    checks += 2;
    if (nerr != 4) begin errors++; $display("FAIL err_count: got %0d faulting NOP responses, required 4", nerr); end
    if (nok != 1) begin errors++; $display("FAIL err_last_word: got %0d good responses, required 1", nok); end
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] got [2];
    int n = 0;
    got = '{32'h0, 32'h0};
    for (int c = 0; c < 8; c++) begin
      bus.wen       = (c == 0);
      bus.waddr     = BASE + 64'h8;
      bus.wdata     = 32'hDEAD_BEEF;
      bus.req_valid = (c < 2);
      bus.req_addr  = BASE + 64'h8;
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        if (n < 2) got[n] = bus.rsp_inst;
        n++;
      end
      cyc();
    end
    bus.wen = 1'b0;
    checks += 3;
    if (n != 2) begin errors++; $display("FAIL wr_rd_count: got %0d, required 2", n); end
    if (got[0] !== 32'h0020_0113) begin errors++; $display("FAIL wr_rd_old: got %h, required 00200113", got[0]); end
    if (got[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_new: got %h, required deadbeef", got[1]); end
  endtask

  task automatic test_reset_midflight();
    int          n = 0;
    bit          seen = 1'b0;
    logic [31:0] inst = '0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_addr = BASE;
    cyc();
    bus.req_addr = BASE + 64'h4;
    cyc();
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks += 2;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp_valid: got %b, required 0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_req_ready: got %b, required 0", bus.req_ready); end
    cyc(); cyc();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_req_ready: got %b, required 1", bus.req_ready); end
      end
      if (bus.rsp_valid === 1'b1) n++;
      cyc();
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL mid_dropped: got %0d responses, required 0", n); end
    bus.req_valid = 1'b1; bus.req_addr = BASE;
    cyc();
    bus.req_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin seen = 1'b1; inst = bus.rsp_inst; end
      cyc();
    end
    checks += 2;
    if (!seen) begin errors++; $display("FAIL mid_fresh_timeout: got no response, required one"); end
    if (inst !== 32'h0010_0093) begin errors++; $display("FAIL mid_fresh_inst: got %h, required 00100093", inst); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_same_cycle_write();
    test_reset_midflight();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
